// File: rtl/i2s_tx_multi.sv
// i2s_tx_multi: I2S / left-justified / TDM audio serializer with a one-frame holding buffer.
// All pin updates happen on BCK falling edges; the receiver samples on the rising edge.
module i2s_tx_multi #(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = 32,
  parameter int CHANNELS = 2,
  parameter int CLK_DIV  = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enable,
  input  logic                         fmt_lj,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_data,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  output logic                         i2s_bck,
  output logic                         i2s_lrck,
  output logic                         i2s_data,
  output logic                         underflow,
  output logic                         frame_start
);
  localparam int FW = CHANNELS * SAMPLE_W;
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int PW = $clog2(SLOT_W);
  localparam int CW = $clog2(CHANNELS);
  logic [DW-1:0] div_cnt;
  logic [PW-1:0] pos, pos_n;
  logic [CW-1:0] slot, slot_n;
  logic [FW-1:0] buf_q, shift_q, frame_n;
  logic          full, run, fmt_q, fmt_n, dly;
  logic          tick, fall, last_pos, last_slot, boundary, lj, lrck_n;
  assign sample_ready = !full;
  assign tick      = div_cnt == DW'(CLK_DIV - 1);
  assign fall      = tick && i2s_bck;
  assign last_pos  = pos == PW'(SLOT_W - 1);
  assign last_slot = slot == CW'(CHANNELS - 1);
  // run is low until the first fall event after enable, which opens a fresh frame
  assign boundary  = fall && (!run || (last_pos && last_slot));
  always_comb begin
    pos_n   = (!run || last_pos) ? '0 : pos + 1'b1;
    slot_n  = !run ? '0 : last_pos ? (last_slot ? '0 : slot + 1'b1) : slot;
    frame_n = boundary ? (full ? buf_q : '0) : shift_q;
    fmt_n   = boundary ? fmt_lj : fmt_q;
    lrck_n  = CHANNELS == 2 ? slot_n[0] : (slot_n == '0 && pos_n == '0);
    lj      = 1'b0;
    // positions at or beyond SAMPLE_W match no bit and stay zero (slot padding)
    for (int c = 0; c < CHANNELS; c++)
      for (int b = 0; b < SAMPLE_W; b++)
        if (slot_n == CW'(c) && pos_n == PW'(SAMPLE_W - 1 - b)) lj = frame_n[c*SAMPLE_W + b];
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      div_cnt     <= '0;
      pos         <= '0;
      slot        <= '0;
      run         <= 1'b0;
      buf_q       <= '0;
      shift_q     <= '0;
      full        <= 1'b0;
      fmt_q       <= 1'b0;
      dly         <= 1'b0;
      i2s_bck     <= 1'b0;
      i2s_lrck    <= 1'b0;
      i2s_data    <= 1'b0;
      underflow   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      underflow   <= 1'b0;
      frame_start <= 1'b0;
      if (enable && boundary) full <= 1'b0;
      if (sample_valid && !full) begin
        buf_q <= sample_data;
        full  <= 1'b1;
      end
      if (!enable) begin
        div_cnt  <= '0;
        pos      <= '0;
        slot     <= '0;
        run      <= 1'b0;
        dly      <= 1'b0;
        i2s_bck  <= 1'b0;
        i2s_lrck <= 1'b0;
        i2s_data <= 1'b0;
      end else begin
        div_cnt     <= tick ? '0 : div_cnt + 1'b1;
        frame_start <= boundary;
        underflow   <= boundary && !full;
        if (tick) i2s_bck <= !i2s_bck;
        if (fall) begin
          pos      <= pos_n;
          slot     <= slot_n;
          run      <= 1'b1;
          shift_q  <= frame_n;
          fmt_q    <= fmt_n;
          dly      <= lj;
          i2s_data <= fmt_n ? lj : dly;
          i2s_lrck <= lrck_n;
        end
      end
    end
endmodule
